// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake, an optional skid entry,
// a synchronous flush and a saturating back-pressure counter.
//
// state     | meaning
// EMPTY     | nothing held, mem_valid=0
// FULL      | main register holds the beat shown to MEM
// SKID_FULL | main and skid both hold beats, input stalled (SKID=1 only)
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic signed [DATA_W-1:0] ex_data_1,
  input  logic signed [DATA_W-1:0] ex_data_2,
  input  logic [REG_W-1:0]         rd_ex,
  input  logic [CTRL_W-1:0]        control_ALU,
  input  logic                     flush,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] mem_addr,
  output logic signed [DATA_W-1:0] save_mem,
  output logic [REG_W-1:0]         rd_mem,
  output logic [CTRL_W-1:0]        control_MEM,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID_FULL} state_t;

  localparam bit HAS_SKID = (SKID != 0);

  state_t                    state;
  logic signed [DATA_W-1:0]  main_d1, main_d2, skid_d1, skid_d2;
  logic [REG_W-1:0]          main_rd, skid_rd;
  logic [CTRL_W-1:0]         main_ctrl, skid_ctrl;
  logic                      in_xfer, out_xfer;

  assign mem_valid = (state != EMPTY);

  // With a skid entry, ready depends only on registered state; otherwise it
  // looks through to mem_ready so a consumed slot can be refilled in the same cycle.
  generate
    if (HAS_SKID) begin : g_ready_skid
      assign ex_ready = reset && (state != SKID_FULL);
    end else begin : g_ready_flow
      assign ex_ready = reset && (!mem_valid || mem_ready);
    end
  endgenerate

  assign in_xfer  = ex_valid && ex_ready;
  assign out_xfer = mem_valid && mem_ready;

  assign data_in     = main_d1;
  assign mem_addr    = main_d2;
  assign save_mem    = main_d2;
  assign rd_mem      = main_rd;
  assign control_MEM = mem_valid ? main_ctrl : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_d1   <= '0;
      main_d2   <= '0;
      main_rd   <= '0;
      main_ctrl <= '0;
      skid_d1   <= '0;
      skid_d2   <= '0;
      skid_rd   <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_d1   <= '0;
      main_d2   <= '0;
      main_rd   <= '0;
      main_ctrl <= '0;
      skid_d1   <= '0;
      skid_d2   <= '0;
      skid_rd   <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_d1   <= ex_data_1;
            main_d2   <= ex_data_2;
            main_rd   <= rd_ex;
            main_ctrl <= control_ALU;
            state     <= FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_d1   <= ex_data_1;
            main_d2   <= ex_data_2;
            main_rd   <= rd_ex;
            main_ctrl <= control_ALU;
          end else if (out_xfer) begin
            state <= EMPTY;
          end else if (in_xfer && HAS_SKID) begin
            skid_d1   <= ex_data_1;
            skid_d2   <= ex_data_2;
            skid_rd   <= rd_ex;
            skid_ctrl <= control_ALU;
            state     <= SKID_FULL;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            main_d1   <= skid_d1;
            main_d2   <= skid_d2;
            main_rd   <= skid_rd;
            main_ctrl <= skid_ctrl;
            state     <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Flush deliberately leaves the stall statistic alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a SKID=1 instance and a SKID=0 instance
// with a 4-bit stall counter share stimulus; each phase checks one of them.
module tb_ex_mem_pipe_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_data_1 = '0;
  logic [31:0] ex_data_2 = '0;
  logic [4:0]  rd_ex = '0;
  logic [7:0]  control_ALU = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;

  logic        ex_ready1, mem_valid1;
  logic [31:0] data_in1, mem_addr1, save_mem1;
  logic [4:0]  rd_mem1;
  logic [7:0]  control_MEM1;
  logic [15:0] stall_cnt1;

  logic        ex_ready0, mem_valid0;
  logic [31:0] data_in0, mem_addr0, save_mem0;
  logic [4:0]  rd_mem0;
  logic [7:0]  control_MEM0;
  logic [3:0]  stall_cnt0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready1),
    .ex_data_1(ex_data_1), .ex_data_2(ex_data_2), .rd_ex(rd_ex), .control_ALU(control_ALU),
    .flush(flush), .mem_valid(mem_valid1), .mem_ready(mem_ready),
    .data_in(data_in1), .mem_addr(mem_addr1), .save_mem(save_mem1), .rd_mem(rd_mem1),
    .control_MEM(control_MEM1), .stall_cnt(stall_cnt1)
  );

  ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_dut_flow (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready0),
    .ex_data_1(ex_data_1), .ex_data_2(ex_data_2), .rd_ex(rd_ex), .control_ALU(control_ALU),
    .flush(flush), .mem_valid(mem_valid0), .mem_ready(mem_ready),
    .data_in(data_in0), .mem_addr(mem_addr0), .save_mem(save_mem0), .rd_mem(rd_mem0),
    .control_MEM(control_MEM0), .stall_cnt(stall_cnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset asserted from time zero
    #1;
    chk("rst_ready", ex_ready1, 1'b0);
    chk("rst_valid", mem_valid1, 1'b0);
    chk("rst_data", data_in1, 32'h0);
    chk("rst_stall", stall_cnt1, 16'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("rel_ready", ex_ready1, 1'b1);
    chk("rel_valid", mem_valid1, 1'b0);

    // streaming, SKID=1
    mem_ready = 1'b1; ex_valid = 1'b1;
    ex_data_1 = 32'h1; ex_data_2 = 32'hFFFF_FFFE; rd_ex = 5'd3; control_ALU = 8'h5A;
    tick();
    chk("st1_data", data_in1, 32'h1);
    chk("st1_valid", mem_valid1, 1'b1);
    chk("st1_addr", mem_addr1, 32'hFFFF_FFFE);
    chk("st1_save", save_mem1, 32'hFFFF_FFFE);
    chk("st1_rd", rd_mem1, 5'd3);
    chk("st1_ctrl", control_MEM1, 8'h5A);
    ex_data_1 = 32'h2;
    tick();
    chk("st2_data", data_in1, 32'h2);
    chk("st2_valid", mem_valid1, 1'b1);
    ex_data_1 = 32'h3;
    tick();
    chk("st3_data", data_in1, 32'h3);
    chk("st3_valid", mem_valid1, 1'b1);
    ex_valid = 1'b0;
    tick();
    chk("drain_valid", mem_valid1, 1'b0);
    chk("drain_ctrl", control_MEM1, 8'h0);
    chk("drain_data", data_in1, 32'h3);
    chk("drain_stall", stall_cnt1, 16'h0);

    // back-pressure, SKID=1
    mem_ready = 1'b0; ex_valid = 1'b1; ex_data_1 = 32'hAAAA_0000;
    tick();
    chk("bpA_data", data_in1, 32'hAAAA_0000);
    chk("bpA_ready", ex_ready1, 1'b1);
    chk("bpA_stall", stall_cnt1, 16'd0);
    ex_data_1 = 32'hBBBB_0000;
    tick();
    chk("bpB_ready", ex_ready1, 1'b0);
    chk("bpB_data", data_in1, 32'hAAAA_0000);
    chk("bpB_stall", stall_cnt1, 16'd1);
    ex_valid = 1'b0;
    tick();
    chk("bph_stall", stall_cnt1, 16'd2);
    chk("bph_data", data_in1, 32'hAAAA_0000);
    mem_ready = 1'b1;
    tick();
    chk("bpr_data", data_in1, 32'hBBBB_0000);
    chk("bpr_valid", mem_valid1, 1'b1);
    chk("bpr_ready", ex_ready1, 1'b1);
    chk("bpr_stall", stall_cnt1, 16'd2);
    tick();
    chk("bpe_valid", mem_valid1, 1'b0);

    // reset mid-stream from SKID_FULL
    mem_ready = 1'b0; ex_valid = 1'b1; ex_data_1 = 32'hC;
    tick();
    ex_data_1 = 32'hD;
    tick();
    chk("mr_skfull", ex_ready1, 1'b0);
    chk("mr_stall_pre", stall_cnt1, 16'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_valid", mem_valid1, 1'b0);
    chk("mr_data", data_in1, 32'h0);
    chk("mr_addr", mem_addr1, 32'h0);
    chk("mr_rd", rd_mem1, 5'd0);
    chk("mr_ctrl", control_MEM1, 8'h0);
    chk("mr_stall", stall_cnt1, 16'd0);
    chk("mr_ready", ex_ready1, 1'b0);
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    chk("mr_rel_ready", ex_ready1, 1'b1);
    chk("mr_rel_valid", mem_valid1, 1'b0);

    // flush from SKID_FULL with a beat offered
    tick();
    mem_ready = 1'b0; ex_valid = 1'b1; control_ALU = 8'h77; ex_data_1 = 32'hE1;
    tick();
    ex_data_1 = 32'hE2;
    tick();
    chk("fl_skfull", ex_ready1, 1'b0);
    ex_data_1 = 32'hE3; flush = 1'b1;
    tick();
    flush = 1'b0; ex_valid = 1'b0;
    chk("fl_valid", mem_valid1, 1'b0);
    chk("fl_ctrl", control_MEM1, 8'h0);
    chk("fl_data", data_in1, 32'h0);
    chk("fl_addr", mem_addr1, 32'h0);
    chk("fl_rd", rd_mem1, 5'd0);
    chk("fl_stall", stall_cnt1, 16'd2);
    mem_ready = 1'b1;
    tick();
    chk("fl_gone1", mem_valid1, 1'b0);
    tick();
    chk("fl_gone2", mem_valid1, 1'b0);

    // SKID=0 back-pressure, fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mem_ready = 1'b0; ex_valid = 1'b1; ex_data_1 = 32'h11;
    #1;
    chk("f_empty_ready", ex_ready0, 1'b1);
    tick();
    chk("f_full_data", data_in0, 32'h11);
    chk("f_full_ready", ex_ready0, 1'b0);
    ex_data_1 = 32'h22; ex_data_2 = 32'h8000_0001; rd_ex = 5'h1F; control_ALU = 8'hC3;
    mem_ready = 1'b1;
    #1;
    chk("f_comb_ready", ex_ready0, 1'b1);
    tick();
    chk("f_load_data", data_in0, 32'h22);
    chk("f_load_valid", mem_valid0, 1'b1);
    chk("f_load_addr", mem_addr0, 32'h8000_0001);
    chk("f_load_save", save_mem0, 32'h8000_0001);
    chk("f_load_rd", rd_mem0, 5'h1F);
    chk("f_load_ctrl", control_MEM0, 8'hC3);
    chk("f_stall0", stall_cnt0, 4'd0);

    // saturation with 4-bit counter
    ex_valid = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", stall_cnt0, 4'd15);
    chk("sat_valid", mem_valid0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_stall", stall_cnt0, 4'd15);
    chk("sat_flush_valid", mem_valid0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
